// File: rtl/shift_pkg.sv
// Shared shift-path definitions: FSM states, shift direction encoding and default word width.
package shift_pkg;

  localparam int unsigned SHIFT_W = 6;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

endpackage : shift_pkg

// File: rtl/word_hold.sv
// Output word register with valid/ready handshake; drops and flags words that arrive while blocked.
module word_hold #(
  parameter int unsigned WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] word,
  input  logic             dout_ready,
  input  logic             ovr_clr,
  output logic [WIDTH-1:0] dataout,
  output logic             dout_valid,
  output logic             overrun
);

  logic blocked_c;

  assign blocked_c = dout_valid & ~dout_ready;

  // A completing word may replace one being drained on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dataout    <= '0;
      dout_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (load && !blocked_c) begin
        dataout    <= word;
        dout_valid <= 1'b1;
      end else if (dout_valid && dout_ready) begin
        dout_valid <= 1'b0;
      end

      if (load && blocked_c) begin
        overrun <= 1'b1;
      end else if (ovr_clr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule : word_hold

// File: rtl/shift_deser.sv
// Serial-to-parallel receiver: collects WIDTH bits MSB- or LSB-first and hands each word to word_hold.
module shift_deser
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = SHIFT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             direction,
  input  logic             dout_ready,
  input  logic             ovr_clr,
  output logic [WIDTH-1:0] dataout,
  output logic             dout_valid,
  output logic             busy,
  output logic             overrun
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic             dir_q, dir_d;
  logic             busy_d;
  logic             dir_eff_c;
  logic [WIDTH-1:0] shifted_c;
  logic             done_c;

  // The first bit of a word uses the live direction; later bits use the latched one.
  always_comb begin
    dir_eff_c = (state_q == IDLE) ? direction : dir_q;
    shifted_c = sreg_q;
    case (dir_eff_c)
      DIR_LEFT:  shifted_c = {sreg_q[WIDTH-2:0], bit_in};
      DIR_RIGHT: shifted_c = {bit_in, sreg_q[WIDTH-1:1]};
      default:   shifted_c = sreg_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sreg_q  <= '0;
      dir_q   <= DIR_RIGHT;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sreg_q  <= sreg_d;
      dir_q   <= dir_d;
      busy    <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sreg_d  = sreg_q;
    dir_d   = dir_q;
    done_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bit_valid) begin
          dir_d   = direction;
          sreg_d  = shifted_c;
          cnt_d   = CNT_W'(1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_valid) begin
          sreg_d = shifted_c;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            cnt_d   = '0;
            state_d = IDLE;
            done_c  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d == SHIFT);
  end

  word_hold #(
    .WIDTH(WIDTH)
  ) u_word_hold (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (done_c),
    .word       (shifted_c),
    .dout_ready (dout_ready),
    .ovr_clr    (ovr_clr),
    .dataout    (dataout),
    .dout_valid (dout_valid),
    .overrun    (overrun)
  );

endmodule : shift_deser

// File: tb/tb_shift_deser.sv
// Self-checking bench for shift_deser: directed scenarios plus randomized traffic against a word-level model.
module tb_shift_deser;
  import shift_pkg::*;

  localparam int unsigned W = SHIFT_W;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         bit_in;
  logic         bit_valid;
  logic         direction;
  logic         dout_ready;
  logic         ovr_clr;
  logic [W-1:0] dataout;
  logic         dout_valid;
  logic         busy;
  logic         overrun;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: pending bits of the current word plus the output stage.
  bit           m_bits[$];
  logic         m_dir;
  logic [W-1:0] m_data;
  logic         m_valid;
  logic         m_ovr;

  shift_deser #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .direction  (direction),
    .dout_ready (dout_ready),
    .ovr_clr    (ovr_clr),
    .dataout    (dataout),
    .dout_valid (dout_valid),
    .busy       (busy),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // First received bit lands at the MSB for left mode, at the LSB for right mode.
  function automatic logic [W-1:0] assemble();
    logic [W-1:0] w;
    w = '0;
    for (int i = 0; i < int'(W); i++) begin
      if (m_bits[i]) begin
        if (m_dir) w = w | (W'(1) << (int'(W) - 1 - i));
        else       w = w | (W'(1) << i);
      end
    end
    return w;
  endfunction

  task automatic model_edge();
    logic         done;
    logic         blocked;
    logic [W-1:0] word;
    done = 1'b0;
    word = '0;
    if (!rst_n) begin
      m_bits.delete();
      m_dir   = 1'b0;
      m_data  = '0;
      m_valid = 1'b0;
      m_ovr   = 1'b0;
    end else begin
      if (bit_valid) begin
        if (m_bits.size() == 0) m_dir = direction;
        m_bits.push_back(bit_in);
        if (m_bits.size() == int'(W)) begin
          word = assemble();
          done = 1'b1;
          m_bits.delete();
        end
      end
      blocked = m_valid && !dout_ready;
      if (done && !blocked) begin
        m_data  = word;
        m_valid = 1'b1;
      end else if (m_valid && dout_ready) begin
        m_valid = 1'b0;
      end
      if (done && blocked) m_ovr = 1'b1;
      else if (ovr_clr)    m_ovr = 1'b0;
    end
  endtask

  task automatic compare();
    chk("dout_valid", 32'(dout_valid), 32'(m_valid));
    chk("busy", 32'(busy), 32'(m_bits.size() != 0));
    chk("overrun", 32'(overrun), 32'(m_ovr));
    if (m_valid) chk("dataout", 32'(dataout), 32'(m_data));
  endtask

  task automatic step(input logic bv, input logic bi, input logic dir,
                      input logic rdy, input logic clr, input logic rst);
    rst_n      = rst;
    bit_valid  = bv;
    bit_in     = bi;
    direction  = dir;
    dout_ready = rdy;
    ovr_clr    = clr;
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  // seq is read left to right as arrival order.
  task automatic send_seq(input logic [W-1:0] seq, input logic dir, input logic rdy);
    for (int i = 0; i < int'(W); i++) begin
      step(1'b1, seq[int'(W) - 1 - i], dir, rdy, 1'b0, 1'b1);
    end
  endtask

  initial begin
    logic [W-1:0] s;
    logic         d;
    m_bits.delete();
    m_dir = 1'b0; m_data = '0; m_valid = 1'b0; m_ovr = 1'b0;

    // Reset
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset_dataout", 32'(dataout), 32'd0);
    chk("reset_valid", 32'(dout_valid), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_overrun", 32'(overrun), 32'd0);

    // Left assembly
    send_seq(6'b101100, 1'b1, 1'b1);
    chk("left_data", 32'(dataout), 32'b101100);
    chk("left_valid", 32'(dout_valid), 32'd1);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("left_drained", 32'(dout_valid), 32'd0);

    // Right assembly
    send_seq(6'b101100, 1'b0, 1'b1);
    chk("right_data", 32'(dataout), 32'b001101);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

    // Gaps with a direction flip after bit 3
    s = 6'b101100;
    for (int i = 0; i < int'(W); i++) begin
      d = (i < 3) ? 1'b1 : 1'b0;
      step(1'b1, s[int'(W) - 1 - i], d, 1'b1, 1'b0, 1'b1);
      if (i < int'(W) - 1) begin
        chk("gap_busy", 32'(busy), 32'd1);
        step(1'b0, 1'b0, d, 1'b1, 1'b0, 1'b1);
        chk("gap_busy_hold", 32'(busy), 32'd1);
      end
    end
    chk("gap_data", 32'(dataout), 32'b101100);
    chk("gap_valid", 32'(dout_valid), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

    // Overrun while blocked, then clear and drain together
    send_seq(6'b111000, 1'b1, 1'b0);
    chk("ovr_first", 32'(dataout), 32'b111000);
    send_seq(6'b000111, 1'b1, 1'b0);
    chk("ovr_kept", 32'(dataout), 32'b111000);
    chk("ovr_set", 32'(overrun), 32'd1);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("ovr_cleared", 32'(overrun), 32'd0);
    chk("ovr_drained", 32'(dout_valid), 32'd0);

    // Drain and completion on the same edge
    send_seq(6'b101010, 1'b1, 1'b0);
    s = 6'b010011;
    for (int i = 0; i < int'(W); i++) begin
      step(1'b1, s[int'(W) - 1 - i], 1'b1, (i == int'(W) - 1), 1'b0, 1'b1);
    end
    chk("sim_valid", 32'(dout_valid), 32'd1);
    chk("sim_data", 32'(dataout), 32'b010011);
    chk("sim_overrun", 32'(overrun), 32'd0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);

    // Reset mid-word
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("rst_mid_dataout", 32'(dataout), 32'd0);
    chk("rst_mid_valid", 32'(dout_valid), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_overrun", 32'(overrun), 32'd0);
    send_seq(6'b010101, 1'b1, 1'b1);
    chk("rst_next_data", 32'(dataout), 32'b010101);
    chk("rst_next_valid", 32'(dout_valid), 32'd1);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      step(logic'($urandom_range(0, 3) != 0),
           logic'($urandom_range(0, 1)),
           logic'($urandom_range(0, 1)),
           logic'($urandom_range(0, 2) != 0),
           logic'($urandom_range(0, 7) == 0),
           logic'($urandom_range(0, 199) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_shift_deser
